shift_unit_pipe: RTL and testbench
==================================

// Module: shift_unit_pipe
// PURPOSE
//  Parametrised, pipelined barrel shifter for the ALU execute path; successor to the fixed 32-bit combinational left shifter.
//  Supports SLL/SRL/SRA (plus rotate when enabled) on WIDTH-bit operands, log2(WIDTH) shift levels split into registered stages.
//  Valid/ready on both sides with full backpressure; carries a sideband tag (dest reg / ROB id) alongside each result.
// PARAMETERS
//  WIDTH       32  operand width; power of two, 8..64
//  PIPE_EVERY  2   shift levels per register stage; NSTAGE = ceil(log2(WIDTH)/PIPE_EVERY) (32/2 -> 3)
//  TAG_W       5   sideband tag width, passed through unmodified
// PORTS
//  clock      in   1                  system clock, all state on rising edge
//  reset_n    in   1                  asynchronous, active-low reset
//  flush      in   1                  synchronous pipeline kill (branch mispredict)
//  in_valid   in   1                  input operand valid
//  in_ready   out  1                  unit can accept input this cycle
//  in_op      in   2                  00 SLL, 01 SRL, 10 SRA, 11 ROL (see CONFIGURATION)
//  in_a       in   WIDTH              operand
//  in_shamt   in   log2(WIDTH)        shift amount, unsigned
//  in_tag     in   TAG_W              sideband tag
//  out_valid  out  1                  result valid
//  out_ready  in   1                  consumer accepts result
//  out_data   out  WIDTH              shifted result
//  out_tag    out  TAG_W              tag of out_data
// BEHAVIOUR
//  - Reset (reset_n=0, async): all stage valid bits, out_valid, out_data, out_tag cleared to 0; in_ready=1 once reset released.
//  - Transfer on in side when in_valid&in_ready; on out side when out_valid&out_ready.
//  - Level order MSB first: level j shifts by 2^(L-1-j) when shamt bit set (16,8,4,2,1 for WIDTH=32).
//  - Stage k holds {valid, op, partial data, remaining shamt bits, tag}; registers after every PIPE_EVERY levels, last stage drives out_*.
//  - Stage k loads when upstream valid and (stage k empty or stage k advancing this cycle); ready chain combinational from out_ready backwards.
//  - Latency NSTAGE cycles accept->out_valid with out_ready=1; throughput 1/cycle; no bubbles under continuous flow.
//  - Stall: out_ready=0 holds out_data/out_tag stable while out_valid=1; upstream stages fill, then in_ready=0.
//  - Arithmetic: SLL zero-fills LSBs; SRL zero-fills MSBs; SRA fills with in_a[WIDTH-1]; shamt=0 passes operand unchanged in all modes.
//  - Right shifts implemented as bit-reverse -> left shift with fill -> bit-reverse; fill bit latched at entry with op.
//  - flush=1: all valids cleared at next edge; input offered that cycle is dropped (in_ready still 1); an out transfer in the same cycle completes normally.
//  - reset_n asserted mid-operation discards all in-flight results; no partial output ever appears.
// CONFIGURATION
//  SHIFT_ROTATE_EN defined: op 11 = ROL, bits shifted out of MSB re-enter at LSB; each level muxes wrap data instead of fill.
//  SHIFT_ROTATE_EN undefined: op 11 decodes as SLL; no wrap muxes synthesised.
// STRUCTURE
//  shift_defs.vh: op encodings (OP_SLL/OP_SRL/OP_SRA/OP_ROL), log2 helper function, NSTAGE derivation.
//  Sub-module shift_level: one conditional shift by constant DIST with fill/wrap select; instantiated log2(WIDTH) times in a generate loop.
//  Top: generate loop over stages, valid/ready chain, bit-reverse at entry/exit for right shifts.
// TESTING
//  1 SLL a=0x0000_0001 shamt=31 -> 0x8000_0000 after 3 cycles, tag preserved.
//  2 SRA a=0x8000_0000 shamt=4 -> 0xF800_0000; SRL same -> 0x0800_0000; shamt=0 any op -> a unchanged.
//  3 Back-to-back 8 ops with out_ready=1 -> 8 results on 8 consecutive cycles, in order, matching model.
//  4 out_ready=0 for 6 cycles during stream -> in_ready drops after 3 accepts, out_data stable, no loss/duplication on release.
//  5 flush with 3 in flight -> out_valid=0 next cycle, none of them emerge; next op emerges with normal latency.
//  6 SHIFT_ROTATE_EN: ROL a=0x8000_0001 shamt=1 -> 0x0000_0003; without macro same stimulus -> 0x0000_0002. Async reset mid-stream -> out_valid=0 immediately.

Source files
------------

// File: rtl/shift_unit_pipe_pkg.sv
// Shared definitions for the pipelined barrel shifter.
//  - shift_op_e : operation encodings (SLL/SRL/SRA/ROL)
//  - log2_f     : ceil(log2(n)) usable in constant expressions
//  - nstage_f   : number of register stages for a width / levels-per-stage pair
package shift_unit_pipe_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROL = 2'b11
  } shift_op_e;

  function automatic int log2_f(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int nstage_f(input int width, input int pe);
    return (log2_f(width) + pe - 1) / pe;
  endfunction

endpackage

// File: rtl/shift_unit_pipe_if.sv
// Handshake bundle for shift_unit_pipe.
//  in side : flush, in_valid/in_ready, in_op, in_a, in_shamt, in_tag
//  out side: out_valid/out_ready, out_data, out_tag
//  master = producer/consumer environment, slave = the shift unit.
interface shift_unit_pipe_if
  import shift_unit_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) ();
  localparam int SHW = log2_f(WIDTH);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  shift_op_e        in_op;
  logic [WIDTH-1:0] in_a;
  logic [SHW-1:0]   in_shamt;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output flush, in_valid, in_op, in_a, in_shamt, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  flush, in_valid, in_op, in_a, in_shamt, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/shift_unit_pipe_level.sv
// One barrel-shifter level: conditional left shift by the constant DIST.
// Vacated LSBs take the fill bit, or the bits shifted out of the MSB end
// when SHIFT_ROTATE_EN is defined and rot is set.
//  en   : apply this level's shift
//  fill : fill bit for vacated LSBs
//  rot  : (SHIFT_ROTATE_EN only) wrap instead of fill
//  d/q  : data in / out
module shift_unit_pipe_level #(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic             en,
  input  logic             fill,
`ifdef SHIFT_ROTATE_EN
  input  logic             rot,
`endif
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [DIST-1:0] low;

`ifdef SHIFT_ROTATE_EN
  assign low = rot ? d[WIDTH-1 -: DIST] : {DIST{fill}};
`else
  assign low = {DIST{fill}};
`endif

  assign q = en ? {d[WIDTH-1-DIST:0], low} : d;
endmodule

// File: rtl/shift_unit_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA, plus ROL when SHIFT_ROTATE_EN is
// defined; otherwise op 11 behaves as SLL).
//  clock, reset_n : rising-edge clock, async active-low reset
//  bus (slave)    : valid/ready in and out sides, flush, tag sideband
// log2(WIDTH) levels, MSB-first (largest distance first), with a register
// after every PIPE_EVERY levels. Right shifts run as
// reverse -> left shift with fill -> reverse, so only left-shift levels exist.
module shift_unit_pipe
  import shift_unit_pipe_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int PIPE_EVERY = 2,
  parameter int TAG_W      = 5
) (
  input logic              clock,
  input logic              reset_n,
  shift_unit_pipe_if.slave bus
);
  localparam int L      = log2_f(WIDTH);
  localparam int NSTAGE = nstage_f(WIDTH, PIPE_EVERY);

  // Entry decode: direction and fill bit are fixed here and travel with the op.
  logic             entry_rev, entry_fill;
  logic [WIDTH-1:0] entry_data;
`ifdef SHIFT_ROTATE_EN
  logic             entry_rot;
  assign entry_rot  = (bus.in_op == OP_ROL);
`endif
  assign entry_rev  = (bus.in_op == OP_SRL) || (bus.in_op == OP_SRA);
  assign entry_fill = (bus.in_op == OP_SRA) && bus.in_a[WIDTH-1];
  assign entry_data = entry_rev ? {<<{bus.in_a}} : bus.in_a;

  logic [NSTAGE-1:0] vld_pipe;
  logic [NSTAGE:0]   rdy;

  // A stage can take new data when empty or when it is itself moving on.
  always_comb begin
    rdy[NSTAGE] = bus.out_ready;
    for (int k = NSTAGE - 1; k >= 0; k--) rdy[k] = ~vld_pipe[k] | rdy[k+1];
  end

  for (genvar gs = 0; gs < NSTAGE; gs++) begin : g_stg
    localparam int  LO   = gs * PIPE_EVERY;
    localparam int  HI   = ((gs + 1) * PIPE_EVERY < L) ? (gs + 1) * PIPE_EVERY - 1 : L - 1;
    localparam int  NL   = HI - LO + 1;
    localparam bit  LAST = (gs == NSTAGE - 1);

    // Upstream view: only the shamt bits not yet consumed are carried.
    logic             up_vld, up_rev, up_fill;
    logic [WIDTH-1:0] up_data, nd;
    logic [L-LO-1:0]  up_shamt;
    logic [TAG_W-1:0] up_tag;
`ifdef SHIFT_ROTATE_EN
    logic             up_rot;
`endif
    logic             vld, load;
    logic [WIDTH-1:0] data;
    logic [TAG_W-1:0] tag;

    if (gs == 0) begin : g_src_in
      assign up_vld   = bus.in_valid;
      assign up_rev   = entry_rev;
      assign up_fill  = entry_fill;
      assign up_data  = entry_data;
      assign up_shamt = bus.in_shamt;
      assign up_tag   = bus.in_tag;
`ifdef SHIFT_ROTATE_EN
      assign up_rot   = entry_rot;
`endif
    end else begin : g_src_stg
      assign up_vld   = vld_pipe[gs-1];
      assign up_rev   = g_stg[gs-1].g_ctl.rev;
      assign up_fill  = g_stg[gs-1].g_ctl.fill;
      assign up_data  = g_stg[gs-1].data;
      assign up_shamt = g_stg[gs-1].g_ctl.shamt;
      assign up_tag   = g_stg[gs-1].tag;
`ifdef SHIFT_ROTATE_EN
      assign up_rot   = g_stg[gs-1].g_ctl.rot;
`endif
    end

    for (genvar gl = 0; gl < NL; gl++) begin : g_lvl
      localparam int SB = L - 1 - LO - gl;  // shamt bit owned by this level
      logic [WIDTH-1:0] d, q;
      if (gl == 0) begin : g_first
        assign d = up_data;
      end else begin : g_chain
        assign d = g_lvl[gl-1].q;
      end
      shift_unit_pipe_level #(.WIDTH(WIDTH), .DIST(1 << SB)) u_lvl (
        .en  (up_shamt[SB]),
        .fill(up_fill),
`ifdef SHIFT_ROTATE_EN
        .rot (up_rot),
`endif
        .d   (d),
        .q   (q)
      );
    end

    assign load          = rdy[gs] & up_vld & ~bus.flush;
    assign vld_pipe[gs]  = vld;

    if (LAST) begin : g_exit
      // Undo the entry reversal so out_data is a plain register.
      assign nd = up_rev ? {<<{g_lvl[NL-1].q}} : g_lvl[NL-1].q;
    end else begin : g_ctl
      localparam int REM = L - 1 - HI;
      logic           rev, fill;
      logic [REM-1:0] shamt;
`ifdef SHIFT_ROTATE_EN
      logic           rot;
`endif
      assign nd = g_lvl[NL-1].q;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          rev   <= 1'b0;
          fill  <= 1'b0;
          shamt <= '0;
`ifdef SHIFT_ROTATE_EN
          rot   <= 1'b0;
`endif
        end else if (load) begin
          rev   <= up_rev;
          fill  <= up_fill;
          shamt <= up_shamt[REM-1:0];
`ifdef SHIFT_ROTATE_EN
          rot   <= up_rot;
`endif
        end
      end
    end

    // Data only moves on a real load, so a stalled output holds steady.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        vld  <= 1'b0;
        data <= '0;
        tag  <= '0;
      end else begin
        if (bus.flush)    vld <= 1'b0;
        else if (rdy[gs]) vld <= up_vld;
        if (load) begin
          data <= nd;
          tag  <= up_tag;
        end
      end
    end
  end

  // Under flush the offered input is dropped, so it is always "accepted".
  assign bus.in_ready  = rdy[0] | bus.flush;
  assign bus.out_valid = vld_pipe[NSTAGE-1];
  assign bus.out_data  = g_stg[NSTAGE-1].data;
  assign bus.out_tag   = g_stg[NSTAGE-1].tag;
endmodule

// File: tb/tb_shift_unit_pipe.sv
// Bench for shift_unit_pipe (WIDTH=32, PIPE_EVERY=2 -> 3 stages).
// Expected results come from plain SV shift operators and a FIFO of
// accepted operations; directed steps followed by a random stream.
module tb_shift_unit_pipe;
  import shift_unit_pipe_pkg::*;

  localparam int WIDTH = 32;
  localparam int TAG_W = 5;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  shift_unit_pipe_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) u_if ();

  shift_unit_pipe #(.WIDTH(WIDTH), .PIPE_EVERY(2), .TAG_W(TAG_W)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (u_if)
  );

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int n_chk = 0, n_fail = 0, n_out = 0, n_acc = 0, cyc = 0, last_out = 0;

  function automatic logic [WIDTH-1:0] model(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                             input logic [4:0] s);
    logic [WIDTH-1:0] r;
    case (op)
      2'd0:    r = a << s;
      2'd1:    r = a >> s;
      2'd2:    r = $signed(a) >>> s;
`ifdef SHIFT_ROTATE_EN
      default: r = (a << s) | (a >> (6'd32 - {1'b0, s}));
`else
      default: r = a << s;
`endif
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [1:0] op, input logic [31:0] a,
                       input logic [4:0] s, input logic [4:0] t);
    u_if.in_valid = v;
    u_if.in_op    = shift_op_e'(op);
    u_if.in_a     = a;
    u_if.in_shamt = s;
    u_if.in_tag   = t;
  endtask

  // Inputs are set at a negedge; sample handshakes, update the scoreboard,
  // then advance to the next negedge.
  task automatic tick();
    exp_t e;
    #1;
    if (u_if.out_valid && u_if.out_ready) begin
      n_out++;
      last_out = cyc;
      chk("sb_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_data", u_if.out_data, e.data);
        chk("sb_tag", u_if.out_tag, e.tag);
      end
    end
    if (u_if.flush) exp_q.delete();
    else if (u_if.in_valid && u_if.in_ready) begin
      n_acc++;
      exp_q.push_back({u_if.in_tag, model(u_if.in_op, u_if.in_a, u_if.in_shamt)});
    end
    @(posedge clock);
    @(negedge clock);
    cyc++;
  endtask

  // Single op into an empty pipe; checks value, tag and 3-cycle latency.
  task automatic run_one(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [4:0] s, input logic [4:0] t, input logic [31:0] exp);
    int lat;
    lat = 0;
    u_if.out_ready = 1'b1;
    u_if.flush     = 1'b0;
    drive(1'b1, op, a, s, t);
    tick();
    drive(1'b0, 2'd0, 32'd0, 5'd0, 5'd0);
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      #1;
      if (u_if.out_valid) begin
        lat = i;
        chk({tag, "_data"}, u_if.out_data, exp);
        chk({tag, "_tag"}, u_if.out_tag, t);
      end
      tick();
    end
    chk({tag, "_lat"}, lat, 3);
  endtask

  task automatic drive_rand();
    drive(1'b1, 2'($urandom), $urandom, 5'($urandom), 5'($urandom));
  endtask

  initial begin
    int o0, o1, c0;
    u_if.flush     = 1'b0;
    u_if.out_ready = 1'b1;
    drive(1'b0, 2'd0, 32'd0, 5'd0, 5'd0);

    // Reset state
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    chk("rst_out_valid", u_if.out_valid, 0);
    chk("rst_out_data", u_if.out_data, 0);
    chk("rst_out_tag", u_if.out_tag, 0);
    @(negedge clock);
    reset_n = 1'b1;
    #1 chk("rst_in_ready", u_if.in_ready, 1);
    @(negedge clock);

    // Directed arithmetic
    run_one("sll31", 2'd0, 32'h0000_0001, 5'd31, 5'h15, 32'h8000_0000);
    run_one("sra4", 2'd2, 32'h8000_0000, 5'd4, 5'h03, 32'hF800_0000);
    run_one("srl4", 2'd1, 32'h8000_0000, 5'd4, 5'h04, 32'h0800_0000);
    for (int op = 0; op < 4; op++)
      run_one("sh0", op[1:0], 32'hA5C3_0F96, 5'd0, op[4:0], 32'hA5C3_0F96);
`ifdef SHIFT_ROTATE_EN
    run_one("op3", 2'd3, 32'h8000_0001, 5'd1, 5'h07, 32'h0000_0003);
`else
    run_one("op3", 2'd3, 32'h8000_0001, 5'd1, 5'h07, 32'h0000_0002);
`endif

    // Back-to-back: 8 results on 8 consecutive cycles
    u_if.out_ready = 1'b1;
    o0 = n_out;
    c0 = cyc;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 2'($urandom), $urandom, 5'($urandom), 5'(i));
      tick();
    end
    drive(1'b0, 2'd0, 32'd0, 5'd0, 5'd0);
    repeat (3) tick();
    chk("b2b_count", n_out - o0, 8);
    chk("b2b_last_cycle", last_out - c0, 10);
    chk("b2b_empty", exp_q.size(), 0);

    // Stall: out_ready low for 6 cycles while input keeps coming
    u_if.out_ready = 1'b0;
    o0 = n_acc;
    for (int i = 0; i < 6; i++) begin
      drive_rand();
      #1;
      if (u_if.out_valid) begin
        chk("stall_hold_data", u_if.out_data, exp_q[0].data);
        chk("stall_hold_tag", u_if.out_tag, exp_q[0].tag);
      end
      tick();
    end
    #1 chk("stall_in_ready", u_if.in_ready, 0);
    chk("stall_accepts", n_acc - o0, 3);
    drive(1'b0, 2'd0, 32'd0, 5'd0, 5'd0);
    u_if.out_ready = 1'b1;
    o1 = n_out;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    chk("stall_drained", n_out - o1, 3);
    chk("stall_empty", exp_q.size(), 0);
    #1 chk("stall_no_dup", u_if.out_valid, 0);
    @(negedge clock);

    // Flush with three ops in flight
    u_if.out_ready = 1'b0;
    repeat (3) begin
      drive_rand();
      tick();
    end
    drive_rand();
    u_if.flush = 1'b1;
    #1 chk("flush_in_ready", u_if.in_ready, 1);
    tick();
    u_if.flush = 1'b0;
    drive(1'b0, 2'd0, 32'd0, 5'd0, 5'd0);
    #1 chk("flush_out_valid", u_if.out_valid, 0);
    u_if.out_ready = 1'b1;
    o1 = n_out;
    repeat (6) tick();
    chk("flush_none_emerge", n_out - o1, 0);
    run_one("post_flush", 2'd1, 32'hF000_000F, 5'd8, 5'h09, 32'h00F0_0000);

    // Asynchronous reset mid-stream
    u_if.out_ready = 1'b0;
    repeat (4) begin
      drive_rand();
      tick();
    end
    drive(1'b0, 2'd0, 32'd0, 5'd0, 5'd0);
    #1 chk("pre_arst_valid", u_if.out_valid, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_out_valid", u_if.out_valid, 0);
    chk("arst_out_data", u_if.out_data, 0);
    exp_q.delete();
    @(negedge clock);
    reset_n = 1'b1;
    u_if.out_ready = 1'b1;
    #1 chk("arst_in_ready", u_if.in_ready, 1);
    @(negedge clock);
    run_one("post_arst", 2'd2, 32'h4000_0000, 5'd30, 5'h1F, 32'h0000_0001);

    // Random stream with backpressure and occasional flush
    for (int i = 0; i < 400; i++) begin
      u_if.out_ready = ($urandom % 3) != 0;
      u_if.flush     = ($urandom % 29) == 0;
      drive(($urandom % 4) != 0, 2'($urandom), $urandom, 5'($urandom), 5'($urandom));
      tick();
    end
    u_if.flush     = 1'b0;
    u_if.out_ready = 1'b1;
    drive(1'b0, 2'd0, 32'd0, 5'd0, 5'd0);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    chk("rand_drained", exp_q.size(), 0);
    #1 chk("rand_idle", u_if.out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end
endmodule
